// File: rtl/digit_entry_buf_pkg.sv
// -----------------------------------------------------------------------------
// digit_entry_pkg
// Shared constants and helpers for the keypad digit entry buffer and the lock
// FSM that drives it.
//   KEY_NONE     : key code meaning "no key pressed"
//   DEF_DIGITS   : default number of digit slots
//   DEF_DIGIT_W  : default bits stored per digit
//   DEF_KEY_W    : default width of the keypad key code
//   DEF_KEY_MAX  : default largest valid key code
//   clog2()      : ceiling log2, used to size the slot counter
// -----------------------------------------------------------------------------
package digit_entry_pkg;

  localparam int KEY_NONE    = 0;
  localparam int DEF_DIGITS  = 3;
  localparam int DEF_DIGIT_W = 2;
  localparam int DEF_KEY_W   = 4;
  localparam int DEF_KEY_MAX = 3;

  // Ceiling log2. The counter must hold 0..DIGITS, so callers pass DIGITS+1,
  // which is always >= 2 and therefore never yields a zero width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/digit_entry_buf_if.sv
// -----------------------------------------------------------------------------
// digit_entry_buf_if
// Bundles every signal exchanged between the lock FSM / keypad side (master)
// and the digit entry buffer (slave).
//   enable    : FSM is in an entry state; keys and backspace are honoured
//   clear     : synchronous clear of the buffer
//   key_valid : keypad level; a key is taken on its rising edge only
//   key_code  : key value, sampled in the rising-edge cycle
//   backspace : level; acts on its rising edge only
//   ref_code  : stored password, slot 0 in the MSBs
//   digits    : entered digits, slot 0 (first entered) in the MSBs
//   count     : number of filled slots
//   full      : count == DIGITS
//   match     : full and digits == ref_code (registered)
//   key_acc   : one-cycle pulse when a key is stored
//   key_err   : one-cycle pulse when a key edge is rejected
//
// Handshake: there is no ready/back-pressure. key_valid and backspace are
// plain levels; each rising edge is one event, consumed in the cycle it is
// seen whether or not it is acted on. The outcome of a key event is reported
// by exactly one of key_acc / key_err in the following cycle (or neither,
// when the event is discarded by clear or by enable being low).
// -----------------------------------------------------------------------------
interface digit_entry_buf_if
  import digit_entry_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int KEY_W   = DEF_KEY_W
);

  localparam int CNT_W = clog2(DIGITS + 1);

  logic                        enable;
  logic                        clear;
  logic                        key_valid;
  logic [KEY_W-1:0]            key_code;
  logic                        backspace;
  logic [DIGITS*DIGIT_W-1:0]   ref_code;
  logic [DIGITS*DIGIT_W-1:0]   digits;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic                        match;
  logic                        key_acc;
  logic                        key_err;

  modport master (
    output enable, clear, key_valid, key_code, backspace, ref_code,
    input  digits, count, full, match, key_acc, key_err
  );

  modport slave (
    input  enable, clear, key_valid, key_code, backspace, ref_code,
    output digits, count, full, match, key_acc, key_err
  );

endinterface

// File: rtl/digit_entry_buf_key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// One-bit synchronous rising-edge detector.
//   clk     : system clock, rising edge
//   rst     : synchronous active-low reset; clears the history to 0 so a
//             level held through reset shows up as a new edge afterwards
//   i_level : input level
//   o_edge  : high in the cycle where i_level is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_edge
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_edge = i_level & ~r_level_q;

endmodule

// File: rtl/digit_entry_buf.sv
// -----------------------------------------------------------------------------
// digit_entry_buf
// Parametrised keypad entry buffer. Collects up to DIGITS key codes in entry
// order with backspace, clear, full/overflow reporting and a registered
// compare against a reference code.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : digit_entry_buf_if slave modport (controls, key inputs, results)
// Parameters:
//   DIGITS  : number of slots (1..8)
//   DIGIT_W : bits stored per digit
//   KEY_W   : width of the incoming key code
//   KEY_MAX : largest valid key code (valid codes are 1..KEY_MAX)
// Per-cycle priority: rst > clear > backspace edge > key edge.
// -----------------------------------------------------------------------------
module digit_entry_buf
  import digit_entry_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int KEY_W   = DEF_KEY_W,
  parameter int KEY_MAX = DEF_KEY_MAX
) (
  input  logic              clk,
  input  logic              rst,
  digit_entry_buf_if.slave  bus
);

  localparam int CNT_W = clog2(DIGITS + 1);
  localparam int BUF_W = DIGITS * DIGIT_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              w_kedge;
  logic              w_bedge;
  logic              w_key_ok;

  logic [BUF_W-1:0]  r_digits;
  logic [CNT_W-1:0]  r_count;
  logic              r_match;
  logic              r_key_acc;
  logic              r_key_err;

  logic [BUF_W-1:0]  w_digits_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_match_next;
  logic              w_key_acc_next;
  logic              w_key_err_next;

  // Edge history runs every cycle independent of enable/clear, so an edge
  // that arrives while disabled is consumed and never replayed later.
  key_edge u_key_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.key_valid),
    .o_edge  (w_kedge)
  );

  key_edge u_bs_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.backspace),
    .o_edge  (w_bedge)
  );

  assign w_key_ok = (int'(bus.key_code) != KEY_NONE) &&
                    (int'(bus.key_code) <= KEY_MAX);

  always_comb begin
    w_digits_next  = r_digits;
    w_count_next   = r_count;
    w_key_acc_next = 1'b0;
    w_key_err_next = 1'b0;

    if (bus.clear) begin
      // Coincident key/backspace edges are discarded silently.
      w_digits_next = '0;
      w_count_next  = '0;
    end else if (bus.enable && w_bedge && (r_count != '0)) begin
      // Backspace wins over a simultaneous key; the key is reported as lost.
      w_count_next = r_count - CNT_ONE;
      for (int i = 0; i < DIGITS; i++) begin
        if (CNT_W'(i) == (r_count - CNT_ONE)) begin
          w_digits_next[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = '0;
        end
      end
      w_key_err_next = w_kedge;
    end else if (bus.enable && w_kedge) begin
      // A backspace on an empty buffer is a no-op and does not block a key.
      if (w_key_ok && (r_count != CNT_FULL)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (CNT_W'(i) == r_count) begin
            w_digits_next[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] =
              bus.key_code[DIGIT_W-1:0];
          end
        end
        w_count_next   = r_count + CNT_ONE;
        w_key_acc_next = 1'b1;
      end else begin
        w_key_err_next = 1'b1;
      end
    end
  end

  // Compare against the next-state values so match lines up with full.
  assign w_match_next = (w_count_next == CNT_FULL) &&
                        (w_digits_next == bus.ref_code);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_digits  <= '0;
      r_count   <= '0;
      r_match   <= 1'b0;
      r_key_acc <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_digits  <= w_digits_next;
      r_count   <= w_count_next;
      r_match   <= w_match_next;
      r_key_acc <= w_key_acc_next;
      r_key_err <= w_key_err_next;
    end
  end

  assign bus.digits  = r_digits;
  assign bus.count   = r_count;
  assign bus.full    = (r_count == CNT_FULL);
  assign bus.match   = r_match;
  assign bus.key_acc = r_key_acc;
  assign bus.key_err = r_key_err;

endmodule

// File: tb/tb_digit_entry_buf.sv
module tb_digit_entry_buf;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_entry_buf_if #(.DIGITS(3), .DIGIT_W(2), .KEY_W(4)) bus3 ();
  digit_entry_buf_if #(.DIGITS(4), .DIGIT_W(3), .KEY_W(4)) bus4 ();

  digit_entry_buf #(.DIGITS(3), .DIGIT_W(2), .KEY_W(4), .KEY_MAX(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  digit_entry_buf #(.DIGITS(4), .DIGIT_W(3), .KEY_W(4), .KEY_MAX(7)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct packed {
    logic [5:0] dig;
    logic [1:0] cnt;
    logic       full;
    logic       match;
    logic       acc;
    logic       err;
  } exp3_t;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       kv;
    logic [3:0] code;
    logic       bs;
    logic [5:0] refc;
    exp3_t      e;
  } vec_t;

  localparam logic [5:0] R = 6'b011110;

  vec_t  vecs[$];
  exp3_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add(input logic rst_n, input logic en, input logic clr, input logic kv,
                     input logic [3:0] code, input logic bs, input logic [5:0] refc,
                     input logic [5:0] dig, input logic [1:0] cnt, input logic full,
                     input logic match, input logic acc, input logic err);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.clr = clr; v.kv = kv; v.code = code; v.bs = bs;
    v.refc = refc;
    v.e.dig = dig; v.e.cnt = cnt; v.e.full = full; v.e.match = match;
    v.e.acc = acc; v.e.err = err;
    vecs.push_back(v);
  endtask

  // Idle cycle on the 3-digit unit: all event inputs low, expectations given.
  task automatic idle(input logic [5:0] dig, input logic [1:0] cnt, input logic full,
                      input logic match);
    add(1, 1, 0, 0, 4'd0, 0, R, dig, cnt, full, match, 0, 0);
  endtask

  task automatic d4_key(input int idx, input logic [3:0] code, input logic [11:0] dig,
                        input logic [2:0] cnt, input logic full, input logic match,
                        input logic acc, input logic err);
    bus4.key_valid = 1'b1;
    bus4.key_code  = code;
    @(posedge clk); #1;
    check($sformatf("d4[%0d].digits", idx), 32'(bus4.digits), 32'(dig));
    check($sformatf("d4[%0d].count", idx), 32'(bus4.count), 32'(cnt));
    check($sformatf("d4[%0d].full", idx), 32'(bus4.full), 32'(full));
    check($sformatf("d4[%0d].match", idx), 32'(bus4.match), 32'(match));
    check($sformatf("d4[%0d].key_acc", idx), 32'(bus4.key_acc), 32'(acc));
    check($sformatf("d4[%0d].key_err", idx), 32'(bus4.key_err), 32'(err));
    bus4.key_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("d4[%0d].idle_acc", idx), 32'(bus4.key_acc), 32'd0);
    check($sformatf("d4[%0d].idle_err", idx), 32'(bus4.key_err), 32'd0);
  endtask

  initial begin
    exp3_t got;
    exp3_t want;

    rst = 1'b0;
    bus3.enable = 1'b0; bus3.clear = 1'b0; bus3.key_valid = 1'b0;
    bus3.key_code = '0; bus3.backspace = 1'b0; bus3.ref_code = R;
    bus4.enable = 1'b0; bus4.clear = 1'b0; bus4.key_valid = 1'b0;
    bus4.key_code = '0; bus4.backspace = 1'b0; bus4.ref_code = 12'o7516;

    // rst en clr kv code bs ref -> digits cnt full match acc err
    // Reset
    add(0, 0, 0, 0, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    // Enter 1,3,2 -> matches R
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b010000, 2'd1, 0, 0, 1, 0);
    idle(6'b010000, 2'd1, 0, 0);
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b011100, 2'd2, 0, 0, 1, 0);
    idle(6'b011100, 2'd2, 0, 0);
    add(1, 1, 0, 1, 4'd2, 0, R, 6'b011110, 2'd3, 1, 1, 1, 0);
    idle(6'b011110, 2'd3, 1, 1);
    // Key while full: rejected, digits kept
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b011110, 2'd3, 1, 1, 0, 1);
    idle(6'b011110, 2'd3, 1, 1);
    // ref_code change while full, then back
    add(1, 1, 0, 0, 4'd0, 0, 6'b000000, 6'b011110, 2'd3, 1, 0, 0, 0);
    idle(6'b011110, 2'd3, 1, 1);
    // Clear
    add(1, 1, 1, 0, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    // Key held 5 cycles: one acceptance only
    add(1, 1, 0, 1, 4'd2, 0, R, 6'b100000, 2'd1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 4'd2, 0, R, 6'b100000, 2'd1, 0, 0, 0, 0);
    idle(6'b100000, 2'd1, 0, 0);
    add(1, 1, 1, 0, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    // Enter 1,2 then backspace x3
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b010000, 2'd1, 0, 0, 1, 0);
    idle(6'b010000, 2'd1, 0, 0);
    add(1, 1, 0, 1, 4'd2, 0, R, 6'b011000, 2'd2, 0, 0, 1, 0);
    idle(6'b011000, 2'd2, 0, 0);
    add(1, 1, 0, 0, 4'd0, 1, R, 6'b010000, 2'd1, 0, 0, 0, 0);
    idle(6'b010000, 2'd1, 0, 0);
    add(1, 1, 0, 0, 4'd0, 1, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    idle(6'b000000, 2'd0, 0, 0);
    add(1, 1, 0, 0, 4'd0, 1, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    idle(6'b000000, 2'd0, 0, 0);
    // Invalid codes from empty
    add(1, 1, 0, 1, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 1);
    idle(6'b000000, 2'd0, 0, 0);
    add(1, 1, 0, 1, 4'd5, 0, R, 6'b000000, 2'd0, 0, 0, 0, 1);
    idle(6'b000000, 2'd0, 0, 0);
    // Key + backspace with count=2
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b010000, 2'd1, 0, 0, 1, 0);
    idle(6'b010000, 2'd1, 0, 0);
    add(1, 1, 0, 1, 4'd2, 0, R, 6'b011000, 2'd2, 0, 0, 1, 0);
    idle(6'b011000, 2'd2, 0, 0);
    add(1, 1, 0, 1, 4'd2, 1, R, 6'b010000, 2'd1, 0, 0, 0, 1);
    idle(6'b010000, 2'd1, 0, 0);
    // Key + clear: silent
    add(1, 1, 1, 1, 4'd3, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    idle(6'b000000, 2'd0, 0, 0);
    // Disabled edge is consumed, not replayed on enable
    add(1, 0, 0, 1, 4'd1, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    idle(6'b000000, 2'd0, 0, 0);
    // Full with a non-matching code
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b110000, 2'd1, 0, 0, 1, 0);
    idle(6'b110000, 2'd1, 0, 0);
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b111100, 2'd2, 0, 0, 1, 0);
    idle(6'b111100, 2'd2, 0, 0);
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b111111, 2'd3, 1, 0, 1, 0);
    idle(6'b111111, 2'd3, 1, 0);
    add(1, 1, 1, 0, 4'd0, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    // Reset mid-entry with key held
    add(1, 1, 0, 1, 4'd1, 0, R, 6'b010000, 2'd1, 0, 0, 1, 0);
    idle(6'b010000, 2'd1, 0, 0);
    add(1, 1, 0, 1, 4'd2, 0, R, 6'b011000, 2'd2, 0, 0, 1, 0);
    idle(6'b011000, 2'd2, 0, 0);
    add(0, 1, 0, 1, 4'd3, 0, R, 6'b000000, 2'd0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b110000, 2'd1, 0, 0, 1, 0);
    add(1, 1, 0, 1, 4'd3, 0, R, 6'b110000, 2'd1, 0, 0, 0, 0);
    idle(6'b110000, 2'd1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst_n;
      bus3.enable    = vecs[i].en;
      bus3.clear     = vecs[i].clr;
      bus3.key_valid = vecs[i].kv;
      bus3.key_code  = vecs[i].code;
      bus3.backspace = vecs[i].bs;
      bus3.ref_code  = vecs[i].refc;
      exp_q.push_back(vecs[i].e);
      @(posedge clk); #1;
      got.dig   = bus3.digits;
      got.cnt   = bus3.count;
      got.full  = bus3.full;
      got.match = bus3.match;
      got.acc   = bus3.key_acc;
      got.err   = bus3.key_err;
      want = exp_q.pop_front();
      check($sformatf("v%0d.digits", i), 32'(got.dig), 32'(want.dig));
      check($sformatf("v%0d.count", i), 32'(got.cnt), 32'(want.cnt));
      check($sformatf("v%0d.full", i), 32'(got.full), 32'(want.full));
      check($sformatf("v%0d.match", i), 32'(got.match), 32'(want.match));
      check($sformatf("v%0d.key_acc", i), 32'(got.acc), 32'(want.acc));
      check($sformatf("v%0d.key_err", i), 32'(got.err), 32'(want.err));
    end
    check("exp_q.empty", 32'(exp_q.size()), 32'd0);

    // Wider configuration: DIGITS=4, DIGIT_W=3, KEY_MAX=7
    rst = 1'b1;
    bus3.key_valid = 1'b0;
    bus3.backspace = 1'b0;
    bus4.enable = 1'b1;
    bus4.clear  = 1'b1;
    @(posedge clk); #1;
    bus4.clear  = 1'b0;
    check("d4.cleared", 32'(bus4.count), 32'd0);
    d4_key(0, 4'd7, 12'o7000, 3'd1, 0, 0, 1, 0);
    d4_key(1, 4'd0, 12'o7000, 3'd1, 0, 0, 0, 1);
    d4_key(2, 4'd5, 12'o7500, 3'd2, 0, 0, 1, 0);
    d4_key(3, 4'd1, 12'o7510, 3'd3, 0, 0, 1, 0);
    d4_key(4, 4'd6, 12'o7516, 3'd4, 1, 1, 1, 0);
    d4_key(5, 4'd3, 12'o7516, 3'd4, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
